// File: rtl/mode_counter.sv
// Multi-mode programmable counter (up-wrap, down-wrap, bounce, one-shot) with a registered terminal-count pulse.
// Optional compare output enabled by defining MODE_COUNTER_CMP_EN.
module mode_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic [1:0]       mode_i,
`ifdef MODE_COUNTER_CMP_EN
  input  logic [WIDTH-1:0] cmp_i,
  output logic             match_o,
`endif
  output logic [WIDTH-1:0] value_o,
  output logic             dir_o,
  output logic             tc_o,
  output logic             done_o
);

  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] value_q, value_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic [0:0]       state_q, state_d;

  logic at_top, at_bot, above, advance;

  assign at_top = (value_q >= limit_i);
  assign at_bot = (value_q == '0);
  assign above  = (value_q > limit_i);
  // DONE only blocks advancing while the counter is still in one-shot mode.
  assign advance = en_i && ((state_q == ST_RUN) || (mode_i != MODE_ONESHOT));

  always_comb begin
    value_d = value_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;

    if ((state_q == ST_DONE) && (mode_i != MODE_ONESHOT)) begin
      state_d = ST_RUN;
    end

    if (clear_i) begin
      value_d = '0;
      dir_d   = 1'b0;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (load_i) begin
      value_d = load_value_i;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (advance) begin
      case (mode_i)
        MODE_UP: begin
          dir_d = 1'b0;
          if (at_top) begin
            value_d = '0;
            tc_d    = 1'b1;
          end else begin
            value_d = value_q + ONE;
          end
        end

        MODE_DOWN: begin
          dir_d = 1'b1;
          // A value stranded above a lowered limit is pulled back to the limit.
          if (above) begin
            value_d = limit_i;
          end else if (at_bot) begin
            value_d = limit_i;
            tc_d    = 1'b1;
          end else begin
            value_d = value_q - ONE;
          end
        end

        MODE_BOUNCE: begin
          if (limit_i == '0) begin
            value_d = '0;
            dir_d   = 1'b0;
            tc_d    = 1'b1;
          end else if (above || (!dir_q && at_top)) begin
            value_d = limit_i - ONE;
            dir_d   = 1'b1;
            tc_d    = !dir_q;
          end else if (dir_q && at_bot) begin
            value_d = ONE;
            dir_d   = 1'b0;
            tc_d    = 1'b1;
          end else if (dir_q) begin
            value_d = value_q - ONE;
          end else begin
            value_d = value_q + ONE;
          end
        end

        default: begin
          dir_d = 1'b0;
          if (at_top) begin
            done_d  = 1'b1;
            tc_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            value_d = value_q + ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      value_q <= value_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

`ifdef MODE_COUNTER_CMP_EN
  logic match_q, match_d;

  assign match_d = !clear_i && (value_d == cmp_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match_o = match_q;
`endif

  assign value_o = value_q;
  assign dir_o   = dir_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter; expected outputs are queued per driven cycle and compared after the edge.
// Compare checks are included when MODE_COUNTER_CMP_EN is defined.
module tb_mode_counter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i, clear_i, load_i;
  logic [7:0] load_value_i, limit_i;
  logic [1:0] mode_i;
  logic [7:0] value_o;
  logic       dir_o, tc_o, done_o;
`ifdef MODE_COUNTER_CMP_EN
  logic [7:0] cmp_i;
  logic       match_o;
`endif

  mode_counter #(.WIDTH(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .clear_i      (clear_i),
    .load_i       (load_i),
    .load_value_i (load_value_i),
    .limit_i      (limit_i),
    .mode_i       (mode_i),
`ifdef MODE_COUNTER_CMP_EN
    .cmp_i        (cmp_i),
    .match_o      (match_o),
`endif
    .value_o      (value_o),
    .dir_o        (dir_o),
    .tc_o         (tc_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic [7:0] value;
    logic       dir;
    logic       tc;
    logic       done;
    logic       match;
    bit         tc_care;
    bit         match_care;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   tc_dc  = 1'b0;
  bit   m_care = 1'b0;
  logic m_exp  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue its expected result, then compare just after the edge.
  task automatic step(input string tag, input logic en, input logic clr, input logic ld,
                      input logic [7:0] lv, input logic [7:0] ev, input logic ed,
                      input logic et, input logic edn);
    exp_t e;
    en_i = en; clear_i = clr; load_i = ld; load_value_i = lv;
    e.tag = tag; e.value = ev; e.dir = ed; e.tc = et; e.done = edn;
    e.match = m_exp; e.tc_care = !tc_dc; e.match_care = m_care;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".value"}, 32'(value_o), 32'(e.value));
      chk({e.tag, ".dir"}, 32'(dir_o), 32'(e.dir));
      if (e.tc_care) chk({e.tag, ".tc"}, 32'(tc_o), 32'(e.tc));
      chk({e.tag, ".done"}, 32'(done_o), 32'(e.done));
`ifdef MODE_COUNTER_CMP_EN
      if (e.match_care) chk({e.tag, ".match"}, 32'(match_o), 32'(e.match));
`endif
    end
    tc_dc = 1'b0;
  endtask

  task automatic adv(input string tag, input logic [7:0] ev, input logic ed,
                     input logic et, input logic edn);
    step(tag, 1'b1, 1'b0, 1'b0, 8'd0, ev, ed, et, edn);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; en_i = 1'b0; clear_i = 1'b0; load_i = 1'b0;
    load_value_i = 8'd0; limit_i = 8'd3; mode_i = 2'b00;
`ifdef MODE_COUNTER_CMP_EN
    cmp_i = 8'd0;
`endif
    #3;
    chk("reset.value", 32'(value_o), 32'd0);
    chk("reset.dir", 32'(dir_o), 32'd0);
    chk("reset.tc", 32'(tc_o), 32'd0);
    chk("reset.done", 32'(done_o), 32'd0);
    #9 rst_i = 1'b0;

    // Up-wrap, L=3
    adv("up1", 8'd1, 0, 0, 0);
    adv("up2", 8'd2, 0, 0, 0);
    adv("up3", 8'd3, 0, 0, 0);
    adv("upwrap", 8'd0, 0, 1, 0);
    adv("up_after", 8'd1, 0, 0, 0);

    // Up-wrap at full-scale limit
    limit_i = 8'd255;
    step("ld254", 0, 0, 1, 8'd254, 8'd254, 0, 0, 0);
    adv("up255", 8'd255, 0, 0, 0);
    adv("up255wrap", 8'd0, 0, 1, 0);

    // Value above lowered limit wraps at once
    limit_i = 8'd3;
    step("ld7", 0, 0, 1, 8'd7, 8'd7, 0, 0, 0);
    adv("above_wrap", 8'd0, 0, 1, 0);

    // Bounce L=2
    mode_i = 2'b10; limit_i = 8'd2;
    step("b_clr", 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);
    adv("b1", 8'd1, 0, 0, 0);
    adv("b2", 8'd2, 0, 0, 0);
    adv("b_turn_dn", 8'd1, 1, 1, 0);
    adv("b0", 8'd0, 1, 0, 0);
    adv("b_turn_up", 8'd1, 0, 1, 0);

    // Bounce L=1 and L=0
    limit_i = 8'd1;
    step("b1_clr", 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);
    adv("bL1_a", 8'd1, 0, 0, 0);
    adv("bL1_b", 8'd0, 1, 1, 0);
    adv("bL1_c", 8'd1, 0, 1, 0);
    limit_i = 8'd0;
    step("b0_clr", 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);
    adv("bL0_a", 8'd0, 0, 1, 0);
    adv("bL0_b", 8'd0, 0, 1, 0);

    // One-shot L=4
    mode_i = 2'b11; limit_i = 8'd4;
    step("os_clr", 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) adv("os_cnt", 8'(i), 0, 0, 0);
    adv("os_done", 8'd4, 0, 1, 1);
    for (int i = 0; i < 10; i++) adv("os_hold", 8'd4, 0, 0, 1);
    step("os_ld1", 0, 0, 1, 8'd1, 8'd1, 0, 0, 0);
    adv("os_r2", 8'd2, 0, 0, 0);
    adv("os_r3", 8'd3, 0, 0, 0);
    adv("os_r4", 8'd4, 0, 0, 0);
    adv("os_done2", 8'd4, 0, 1, 1);

    // Leaving one-shot while DONE resumes counting; done stays sticky
    mode_i = 2'b00;
    adv("leave_os", 8'd0, 0, 1, 1);
    adv("leave_os2", 8'd1, 0, 0, 1);
    step("clr_done", 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);

    // Down-wrap with limit lowered below value
    mode_i = 2'b01; limit_i = 8'd15;
    step("dn_ld9", 0, 0, 1, 8'd9, 8'd9, 0, 0, 0);
    limit_i = 8'd5;
    tc_dc = 1'b1;
    adv("dn_clamp", 8'd5, 1, 0, 0);
    adv("dn4", 8'd4, 1, 0, 0);
    step("dn_ld1", 0, 0, 1, 8'd1, 8'd1, 1, 0, 0);
    adv("dn0", 8'd0, 1, 0, 0);
    adv("dn_wrap", 8'd5, 1, 1, 0);
    step("en_low", 0, 0, 0, 8'd0, 8'd5, 1, 0, 0);

    // Simultaneous controls
    mode_i = 2'b00; limit_i = 8'd15;
    step("clr_ld_en", 1, 1, 1, 8'd7, 8'd0, 0, 0, 0);
    step("ld_en", 1, 0, 1, 8'd7, 8'd7, 0, 0, 0);

`ifdef MODE_COUNTER_CMP_EN
    // Compare: match one cycle per lap, aligned with value 2
    cmp_i = 8'd2; limit_i = 8'd3; m_care = 1'b1;
    m_exp = 1'b0; step("c_clr", 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);
    m_exp = 1'b0; adv("c1", 8'd1, 0, 0, 0);
    m_exp = 1'b1; adv("c2", 8'd2, 0, 0, 0);
    m_exp = 1'b0; adv("c3", 8'd3, 0, 0, 0);
    m_exp = 1'b0; adv("c0", 8'd0, 0, 1, 0);
    m_exp = 1'b0; adv("c1b", 8'd1, 0, 0, 0);
    m_exp = 1'b1; adv("c2b", 8'd2, 0, 0, 0);
    m_exp = 1'b1; step("c_hold", 0, 0, 0, 8'd0, 8'd2, 0, 0, 0);
    m_care = 1'b0;
`endif

    // Async reset mid-count with tc and done asserted
    mode_i = 2'b11; limit_i = 8'd5;
    step("r_clr", 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);
    step("r_ld5", 0, 0, 1, 8'd5, 8'd5, 0, 0, 0);
    adv("r_done", 8'd5, 0, 1, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst.value", 32'(value_o), 32'd0);
    chk("async_rst.tc", 32'(tc_o), 32'd0);
    chk("async_rst.done", 32'(done_o), 32'd0);
    chk("async_rst.dir", 32'(dir_o), 32'd0);
    #3 rst_i = 1'b0;
    en_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
